// File: rtl/cell_histogram_accumulator.sv
// ============================================================================
// Module   : cell_histogram_accumulator
// Brief    : Sums CELL_ROWS per-row partial histograms into one cell histogram;
//            the accumulator and output register let the next cell start while
//            the previous one is still being drained. Optional macro HIST_SAT_EN
//            selects saturating adds and a sticky out_sat flag.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cell_histogram_accumulator #(
  parameter int INPUT_BIN_WIDTH  = 11,
  parameter int OUTPUT_BIN_WIDTH = 14,
  parameter int BINS             = 9,
  parameter int CELL_ROWS        = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [INPUT_BIN_WIDTH*BINS-1:0]  in_histogram,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUTPUT_BIN_WIDTH*BINS-1:0] out_histogram,
  output logic                             out_sat
);

  localparam int CNT_W = (CELL_ROWS > 1) ? $clog2(CELL_ROWS) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(CELL_ROWS - 1);

  logic [CNT_W-1:0]                        row_cnt_q, row_cnt_d;
  logic [BINS-1:0][OUTPUT_BIN_WIDTH-1:0]   acc_q, acc_d;
  logic [BINS-1:0][OUTPUT_BIN_WIDTH-1:0]   out_hist_q, out_hist_d;
  logic [BINS-1:0][OUTPUT_BIN_WIDTH-1:0]   sum_w;
  logic                                    out_valid_q, out_valid_d;
  logic                                    first_row, last_row, accept, load_out;

  assign first_row = (row_cnt_q == '0);
  assign last_row  = (row_cnt_q == LAST_ROW);
  // Only the closing beat needs a free output register; earlier rows never stall.
  assign in_ready  = !clear && !(last_row && out_valid_q && !out_ready);
  assign accept    = in_valid && in_ready;
  assign load_out  = accept && last_row;

`ifdef HIST_SAT_EN
  localparam int SUM_W = ((INPUT_BIN_WIDTH > OUTPUT_BIN_WIDTH) ?
                          INPUT_BIN_WIDTH : OUTPUT_BIN_WIDTH) + 1;
  localparam logic [SUM_W-1:0] BIN_MAX = SUM_W'({OUTPUT_BIN_WIDTH{1'b1}});

  logic [BINS-1:0] clip_w;
  logic            acc_clip_q, acc_clip_d, out_sat_q, out_sat_d, cell_clip;

  for (genvar b = 0; b < BINS; b++) begin : g_bin
    logic [SUM_W-1:0] base_w, raw_w;
    assign base_w    = first_row ? '0 : SUM_W'(acc_q[b]);
    assign raw_w     = base_w + SUM_W'(in_histogram[b*INPUT_BIN_WIDTH +: INPUT_BIN_WIDTH]);
    assign clip_w[b] = (raw_w > BIN_MAX);
    assign sum_w[b]  = clip_w[b] ? BIN_MAX[OUTPUT_BIN_WIDTH-1:0] : raw_w[OUTPUT_BIN_WIDTH-1:0];
  end

  // A clipped bin stays at max on later adds, so one sticky flag per cell suffices.
  assign cell_clip = (|clip_w) || (!first_row && acc_clip_q);

  always_comb begin
    acc_clip_d = acc_clip_q;
    out_sat_d  = out_sat_q;
    if (accept && !last_row) acc_clip_d = cell_clip;
    if (load_out)            out_sat_d  = cell_clip;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_clip_q <= 1'b0;
      out_sat_q  <= 1'b0;
    end else begin
      acc_clip_q <= acc_clip_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign out_sat = out_sat_q;
`else
  for (genvar b = 0; b < BINS; b++) begin : g_bin
    logic [OUTPUT_BIN_WIDTH-1:0] base_w;
    assign base_w   = first_row ? '0 : acc_q[b];
    assign sum_w[b] = base_w +
                      OUTPUT_BIN_WIDTH'(in_histogram[b*INPUT_BIN_WIDTH +: INPUT_BIN_WIDTH]);
  end

  assign out_sat = 1'b0;
`endif

  always_comb begin
    row_cnt_d   = row_cnt_q;
    acc_d       = acc_q;
    out_hist_d  = out_hist_q;
    out_valid_d = out_valid_q;
    if (out_ready) out_valid_d = 1'b0;
    if (clear) begin
      row_cnt_d = '0;
    end else if (accept) begin
      if (last_row) begin
        row_cnt_d   = '0;
        out_hist_d  = sum_w;
        out_valid_d = 1'b1;
      end else begin
        row_cnt_d = row_cnt_q + 1'b1;
        acc_d     = sum_w;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt_q   <= '0;
      acc_q       <= '0;
      out_hist_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      row_cnt_q   <= row_cnt_d;
      acc_q       <= acc_d;
      out_hist_q  <= out_hist_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_histogram = out_hist_q;

endmodule

`default_nettype wire

// File: tb/tb_cell_histogram_accumulator.sv
// ============================================================================
// Module   : tb_cell_histogram_accumulator
// Brief    : Directed self-checking bench for cell_histogram_accumulator.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cell_histogram_accumulator;

  localparam int IW   = 11;
  localparam int OW   = 14;
  localparam int OW12 = 12;
  localparam int BINS = 9;
  localparam int ROWS = 8;

  logic                 clk = 1'b0;
  logic                 rst_n, clear, in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [IW*BINS-1:0]   in_histogram;
  logic [OW*BINS-1:0]   out_histogram;

  logic                 clear12, in_valid12, in_ready12, out_valid12, out_ready12, out_sat12;
  logic [IW*BINS-1:0]   in_hist12;
  logic [OW12*BINS-1:0] out_hist12;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cell_histogram_accumulator #(
    .INPUT_BIN_WIDTH(IW), .OUTPUT_BIN_WIDTH(OW), .BINS(BINS), .CELL_ROWS(ROWS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_histogram(in_histogram),
    .out_valid(out_valid), .out_ready(out_ready), .out_histogram(out_histogram),
    .out_sat(out_sat)
  );

  cell_histogram_accumulator #(
    .INPUT_BIN_WIDTH(IW), .OUTPUT_BIN_WIDTH(OW12), .BINS(BINS), .CELL_ROWS(ROWS)
  ) dut12 (
    .clk(clk), .rst_n(rst_n), .clear(clear12),
    .in_valid(in_valid12), .in_ready(in_ready12), .in_histogram(in_hist12),
    .out_valid(out_valid12), .out_ready(out_ready12), .out_histogram(out_hist12),
    .out_sat(out_sat12)
  );

  typedef struct {
    string name;
    int    first;    // row 0 value of bin 0
    int    rinc;     // per-row increment
    int    step;     // per-bin increment within a row
    int    exp_sum;  // hand-computed bin-0 total
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IW*BINS-1:0] row_hist(input int base, input int step);
    logic [IW*BINS-1:0] h;
    for (int b = 0; b < BINS; b++) h[b*IW +: IW] = IW'(base + b*step);
    return h;
  endfunction

  // Every row adds b*step to bin b, so a full cell adds ROWS*b*step.
  function automatic logic [OW*BINS-1:0] exp_hist(input int sum, input int step);
    logic [OW*BINS-1:0] e;
    for (int b = 0; b < BINS; b++) e[b*OW +: OW] = OW'(sum + ROWS*b*step);
    return e;
  endfunction

  // Presents one beat and returns at posedge+1 after it was accepted.
  task automatic beat(input logic [IW*BINS-1:0] h);
    in_histogram = h;
    in_valid     = 1'b1;
    #1;
    for (int n = 0; n < 50; n++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    check("beat_timeout", 1'b0, 1'b1);
  endtask

  task automatic run_vec(input string name, input int first, input int rinc,
                         input int step, input int exp_sum);
    for (int r = 0; r < ROWS; r++) begin
      if (r == ROWS-1) check({name, "_pre_valid"}, out_valid, 1'b0);
      beat(row_hist(first + r*rinc, step));
    end
    in_valid = 1'b0;
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_hist"}, out_histogram, exp_hist(exp_sum, step));
    @(posedge clk); #1;
    check({name, "_valid_drop"}, out_valid, 1'b0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [25:0] ov_log;
    int          ir_low;

    vecs[0] = '{"ramp",    1,    1,    0, 36};
    vecs[1] = '{"full",    2047, 0,    0, 16376};
    vecs[2] = '{"zero",    0,    0,    0, 0};
    vecs[3] = '{"binstep", 100,  100,  1, 3600};
    vecs[4] = '{"down",    1000, -100, 10, 5200};
    vecs[5] = '{"big",     2047, -200, 0, 10776};

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_histogram = '0;
    clear12 = 1'b0; in_valid12 = 1'b0; out_ready12 = 1'b1; in_hist12 = '0;

    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_hist", out_histogram, '0);
    check("rst_out_sat", out_sat, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1'b1);

    foreach (vecs[i]) run_vec(vecs[i].name, vecs[i].first, vecs[i].rinc, vecs[i].step, vecs[i].exp_sum);

    // Three back-to-back cells; cell k has every bin equal to k+1.
    ov_log = '0; ir_low = 0;
    for (int c = 0; c < 26; c++) begin
      in_valid     = (c < 24);
      in_histogram = row_hist(c/8 + 1, 0);
      #1;
      if (c < 24 && !in_ready) ir_low++;
      ov_log[c] = out_valid;
      if (out_valid) check("b2b_hist", out_histogram, exp_hist(c, 0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("b2b_in_ready_low_cycles", 128'(ir_low), 128'd0);
    check("b2b_out_valid_pattern", 128'(ov_log), 128'h1010100);

    // Held output blocks the closing beat of the next cell.
    out_ready = 1'b0;
    for (int r = 0; r < ROWS; r++) beat(row_hist(5, 0));
    for (int r = 0; r < ROWS-1; r++) beat(row_hist(7, 0));
    check("stall_rows_accepted_valid", out_valid, 1'b1);
    in_histogram = row_hist(7, 0);
    in_valid     = 1'b1;
    #1;
    check("stall_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    check("stall_in_ready_hold", in_ready, 1'b0);
    check("stall_hist_stable", out_histogram, exp_hist(40, 0));
    out_ready = 1'b1;
    #1;
    check("stall_release_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("stall_reload_valid", out_valid, 1'b1);
    check("stall_reload_hist", out_histogram, exp_hist(56, 0));
    @(posedge clk); #1;
    check("stall_drain", out_valid, 1'b0);

    // clear discards three partial beats.
    for (int r = 0; r < 3; r++) beat(row_hist(100, 0));
    clear    = 1'b1;
    in_valid = 1'b1;
    #1;
    check("clear_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    clear = 1'b0;
    run_vec("clear_full", 2047, 0, 0, 16376);

    // Reset with a held output and a partial cell in flight.
    out_ready = 1'b0;
    for (int r = 0; r < ROWS; r++) beat(row_hist(r + 1, 0));
    for (int r = 0; r < 3; r++) beat(row_hist(9, 0));
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_hist", out_histogram, '0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    check("midrst_in_ready", in_ready, 1'b1);
    run_vec("post_reset", 1, 1, 0, 36);

    // Narrow output bins: 8 x 2047 exceeds 12 bits.
    in_hist12  = row_hist(2047, 0);
    in_valid12 = 1'b1;
    repeat (ROWS) begin
      #1;
      check("w12_in_ready", in_ready12, 1'b1);
      @(posedge clk); #1;
    end
    in_valid12 = 1'b0;
    check("w12_valid", out_valid12, 1'b1);
`ifdef HIST_SAT_EN
    check("w12_hist", out_hist12, {BINS{12'd4095}});
    check("w12_sat", out_sat12, 1'b1);
`else
    check("w12_hist", out_hist12, {BINS{12'd4088}});
    check("w12_sat", out_sat12, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
